// File: rtl/pipeline_adder_pkg.sv
// Shared defaults and types for the pipeline_adder datapath family.
// The divisibility check is evaluated here for the defaults and again per instance.
package pipeline_adder_pkg;

    localparam int WIDTH  = 64;
    localparam int STAGES = 4;
    localparam int SW     = WIDTH / STAGES;

    typedef logic [SW-1:0] slice_t;

    function automatic bit stages_divide(input int w, input int s);
        return (s > 0) && ((w % s) == 0);
    endfunction

    localparam bit DEFAULTS_OK = stages_divide(WIDTH, STAGES);

endpackage

// File: rtl/sub_slice.sv
// Combinational ripple-borrow subtractor for one pipeline slice: d = a - b - bin.
module sub_slice #(
    parameter int SW = 16
) (
    input  logic [SW-1:0] a,
    input  logic [SW-1:0] b,
    input  logic          bin,
    output logic [SW-1:0] d,
    output logic          bout
);

    logic w_brw;

    // Borrow ripples from bit 0 upward; a bit borrows when a<b, or a==b with a pending borrow.
    always_comb begin
        w_brw = bin;
        d     = '0;
        for (int i = 0; i < SW; i++) begin
            d[i]  = a[i] ^ b[i] ^ w_brw;
            w_brw = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & w_brw);
        end
        bout = w_brw;
    end

endmodule

// File: rtl/pipeline_subtractor.sv
// Pipelined unsigned subtractor: diff = a - b - bin with borrow-out, one slice per stage,
// valid/ready handshake with a single global advance enable.
module pipeline_subtractor #(
    parameter int WIDTH  = pipeline_adder_pkg::WIDTH,
    parameter int STAGES = pipeline_adder_pkg::STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    import pipeline_adder_pkg::*;

    localparam int SW = WIDTH / STAGES;

    if (!stages_divide(WIDTH, STAGES) || !DEFAULTS_OK) begin : g_cfg_check
        $error("pipeline_subtractor: WIDTH must be a multiple of STAGES");
    end

    logic w_adv;

    assign w_adv    = !out_valid || out_ready;
    assign in_ready = w_adv;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [SW-1:0]         w_a;
        logic [SW-1:0]         w_b;
        logic                  w_bi;
        logic [SW-1:0]         w_d;
        logic                  w_bo;
        logic                  w_vld_in;
        logic [(k+1)*SW-1:0]   w_d_all;
        logic [(k+1)*SW-1:0]   r_d;
        logic                  r_bout;
        logic                  r_vld;

        if (k == 0) begin : g_head
            assign w_a      = a[SW-1:0];
            assign w_b      = b[SW-1:0];
            assign w_bi     = bin;
            assign w_vld_in = in_valid;
            assign w_d_all  = w_d;
        end else begin : g_body
            assign w_a      = g_stage[k-1].g_fwd.r_a[SW-1:0];
            assign w_b      = g_stage[k-1].g_fwd.r_b[SW-1:0];
            assign w_bi     = g_stage[k-1].r_bout;
            assign w_vld_in = g_stage[k-1].r_vld;
            assign w_d_all  = {w_d, g_stage[k-1].r_d};
        end

        sub_slice #(.SW(SW)) u_sub (
            .a    (w_a),
            .b    (w_b),
            .bin  (w_bi),
            .d    (w_d),
            .bout (w_bo)
        );

        // Result slices computed so far, running borrow and valid bit.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_d    <= '0;
                r_bout <= 1'b0;
                r_vld  <= 1'b0;
            end else if (w_adv) begin
                r_d    <= w_d_all;
                r_bout <= w_bo;
                r_vld  <= w_vld_in;
            end
        end

        // Operand bits above this slice travel alongside until their own stage.
        if (k < STAGES - 1) begin : g_fwd
            localparam int RW = WIDTH - (k + 1) * SW;
            logic [RW-1:0] w_a_up;
            logic [RW-1:0] w_b_up;
            logic [RW-1:0] r_a;
            logic [RW-1:0] r_b;

            if (k == 0) begin : g_src_in
                assign w_a_up = a[WIDTH-1:SW];
                assign w_b_up = b[WIDTH-1:SW];
            end else begin : g_src_reg
                assign w_a_up = g_stage[k-1].g_fwd.r_a[WIDTH-k*SW-1:SW];
                assign w_b_up = g_stage[k-1].g_fwd.r_b[WIDTH-k*SW-1:SW];
            end

            // Pending upper operand slices.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_a <= '0;
                    r_b <= '0;
                end else if (w_adv) begin
                    r_a <= w_a_up;
                    r_b <= w_b_up;
                end
            end
        end
    end

    assign out_valid = g_stage[STAGES-1].r_vld;
    assign diff      = g_stage[STAGES-1].r_d;
    assign bout      = g_stage[STAGES-1].r_bout;

endmodule
